// File: rtl/syn_fifo_pkg.sv
// rtl/syn_fifo_pkg.sv - default constants and read-mode type for the synchronous FIFO
package syn_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AE_LEVEL   = 2;

  typedef enum logic {
    RD_REG  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// rtl/syn_fifo_mem.sv - FIFO storage array, one write port and one asynchronous read port
module syn_fifo_mem
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_flags.sv
// rtl/syn_fifo_flags.sv - synchronous FIFO pointers, status flags, sticky errors and read port
module syn_fifo_flags
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    clr_err,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    r_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam rd_mode_e RD_MODE = (FWFT != 0) ? RD_FWFT : RD_REG;

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("syn_fifo_flags: DEPTH must be a power of two >= 4");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("syn_fifo_flags: DATA_WIDTH must be >= 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
    $error("syn_fifo_flags: AF_LEVEL out of range 1..DEPTH-1");
  end
  if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("syn_fifo_flags: AE_LEVEL out of range 1..DEPTH-1");
  end

  logic [PW-1:0]         w_ptr, r_ptr;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head;

  // Pointer MSB is the wrap bit: equal indices mean empty or full depending on it.
  assign empty        = (w_ptr == r_ptr);
  assign full         = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);
  assign count        = w_ptr - r_ptr;
  assign almost_full  = (count >= PW'(AF_LEVEL));
  assign almost_empty = (count <= PW'(AE_LEVEL));

  assign wr_acc = w_en && !full && !flush;
  assign rd_acc = r_en && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + PW'(1);
      if (rd_acc) r_ptr <= r_ptr + PW'(1);
      overflow  <= (overflow  && !clr_err) || (w_en && full);
      underflow <= (underflow && !clr_err) || (r_en && empty);
    end
  end

  syn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (w_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (r_ptr[AW-1:0]),
    .rdata (head)
  );

  if (RD_MODE == RD_REG) begin : g_rd_reg
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout_q <= '0;
      else if (rd_acc) dout_q <= head;
    end
    assign data_out = dout_q;
  end else begin : g_rd_fwft
    // Shadow of the last visible head so the output holds steady once empty.
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout_q <= '0;
      else if (!empty) dout_q <= head;
    end
    assign data_out = empty ? dout_q : head;
  end

endmodule

// File: tb/tb_syn_fifo_flags.sv
// tb/tb_syn_fifo_flags.sv - scoreboard bench for syn_fifo_flags in registered and FWFT modes
module tb_syn_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       w_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       r_en = 1'b0;

  logic [7:0] data_out, f_data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] count, f_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb_q[$];
  int         mcount = 0;
  logic       popped;
  logic [7:0] exp_pop;

  always #5 clk = ~clk;

  syn_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  syn_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(f_data_out),
    .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
    .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    logic acc_w, acc_r;
    acc_w = w && (mcount < 16);
    acc_r = r && (mcount > 0);
    w_en = w; data_in = d; r_en = r; flush = 1'b0; clr_err = 1'b0;
    popped = 1'b0;
    if (acc_w) sb_q.push_back(d);
    @(posedge clk); #1;
    if (acc_r) begin
      exp_pop = sb_q.pop_front();
      popped = 1'b1;
    end
    mcount = mcount + int'(acc_w) - int'(acc_r);
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({count, empty, almost_empty, full, almost_full, overflow, underflow, data_out} !==
        {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_state: cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b d=%h required 0 1 1 0 0 0 0 00",
               count, empty, almost_empty, full, almost_full, overflow, underflow, data_out);
    end
    checks++;
    if (f_empty !== 1'b1 || f_data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_fwft: empty=%b data=%h required 1 00", f_empty, f_data_out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      checks++;
      if (count !== 5'(i) || full !== (i == 16) || almost_full !== (i >= 14) ||
          almost_empty !== (i <= 2)) begin
        failures++;
        $display("FAIL fill_flags[%0d]: cnt=%0d f=%b af=%b ae=%b required %0d %b %b %b",
                 i, count, full, almost_full, almost_empty, i, i == 16, i >= 14, i <= 2);
      end
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (!popped || data_out !== exp_pop) begin
        failures++;
        $display("FAIL drain_data[%0d]: got %h required %h", i, data_out, exp_pop);
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      failures++;
      $display("FAIL drain_empty: empty=%b cnt=%0d required 1 0", empty, count);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      failures++;
      $display("FAIL overflow_set: ov=%b cnt=%0d required 1 16", overflow, count);
    end
    w_en = 1'b1; data_in = 8'hAA; clr_err = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0; clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set_wins: ov=%b required 1", overflow);
    end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear: ov=%b required 0", overflow);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (!popped || data_out !== exp_pop || data_out === 8'hAA) begin
        failures++;
        $display("FAIL overflow_drain[%0d]: got %h required %h", i, data_out, exp_pop);
      end
    end
  endtask

  task automatic test_underflow;
    logic [7:0] d0;
    d0 = data_out;
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (underflow !== 1'b1 || data_out !== d0 || count !== 5'd0) begin
      failures++;
      $display("FAIL underflow_set: un=%b data=%h cnt=%0d required 1 %h 0", underflow, data_out, count, d0);
    end
    cycle(1'b1, 8'h33, 1'b1);
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || data_out !== d0) begin
      failures++;
      $display("FAIL empty_wr_rd: cnt=%0d un=%b data=%h required 1 1 %h", count, underflow, data_out, d0);
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (!popped || data_out !== exp_pop) begin
      failures++;
      $display("FAIL empty_wr_rd_data: got %h required %h", data_out, exp_pop);
    end
  endtask

  task automatic test_fwft;
    cycle(1'b1, 8'h5C, 1'b0);
    checks++;
    if (f_empty !== 1'b0 || f_data_out !== 8'h5C) begin
      failures++;
      $display("FAIL fwft_visible: empty=%b data=%h required 0 5c", f_empty, f_data_out);
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (f_empty !== 1'b1 || f_data_out !== 8'h5C || data_out !== exp_pop) begin
      failures++;
      $display("FAIL fwft_pop: empty=%b fdata=%h rdata=%h required 1 5c %h",
               f_empty, f_data_out, data_out, exp_pop);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      checks++;
      if (count !== 5'd8 || f_count !== 5'd8 || !popped || data_out !== exp_pop) begin
        failures++;
        $display("FAIL b2b[%0d]: cnt=%0d fcnt=%0d data=%h required 8 8 %h",
                 i, count, f_count, data_out, exp_pop);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (!popped || data_out !== exp_pop) begin
        failures++;
        $display("FAIL b2b_drain[%0d]: got %h required %h", i, data_out, exp_pop);
      end
    end
  endtask

  task automatic test_flush_reset;
    logic [7:0] d0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    d0 = data_out;
    w_en = 1'b1; data_in = 8'hEE; r_en = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
    sb_q.delete(); mcount = 0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0 || data_out !== d0) begin
      failures++;
      $display("FAIL flush: cnt=%0d e=%b un=%b data=%h required 0 1 0 %h", count, empty, underflow, data_out, d0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    w_en = 1'b1; data_in = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({count, empty, almost_empty, full, almost_full, overflow, underflow, data_out} !==
        {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL async_reset: cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b d=%h required 0 1 1 0 0 0 0 00",
               count, empty, almost_empty, full, almost_full, overflow, underflow, data_out);
    end
    w_en = 1'b0;
    sb_q.delete(); mcount = 0;
    @(negedge clk); rst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (!popped || data_out !== exp_pop || empty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: data=%h empty=%b required %h 1", data_out, empty, exp_pop);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_fwft();
    test_back_to_back();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
